// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port cache refill arbiter.
//   BEAT_W  : width of one memory-bus beat
//   LINE_W  : width of one assembled cache line (DMEM_LINE)
//   BEATS   : beats per line
//   BLK_LEN : block-address width (DMEM_BLK_LEN)
//   state_t : arbiter FSM states
//   req_id_t: which cache owns the current transaction
package mem_arb_pkg;

  localparam int DMEM_LINE    = 256;
  localparam int DMEM_BLK_LEN = 27;

  localparam int BEAT_W  = 64;
  localparam int LINE_W  = DMEM_LINE;
  localparam int BEATS   = LINE_W / BEAT_W;
  localparam int BLK_LEN = DMEM_BLK_LEN;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arb_linebuf.sv
// Beat assembly buffer: collects BEATS memory beats into one line.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   cap       : store beat into the current slot this cycle
//   beat      : memory beat data
//   line_nxt  : line including the beat being captured this cycle
//   last      : the beat being captured is the final beat of the line
module mem_arb_linebuf
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [BEAT_W-1:0] beat,
  output logic [LINE_W-1:0] line_nxt,
  output logic              last
);

  logic [CNT_W-1:0]  beat_cnt;
  logic [LINE_W-1:0] line_q;

  // Expose the line with the incoming beat already merged so the owner can
  // latch a complete line on the same edge that captures the last beat.
  always_comb begin
    line_nxt = line_q;
    for (int s = 0; s < BEATS; s++) begin
      if (cap && (beat_cnt == CNT_W'(s))) begin
        line_nxt[s*BEAT_W +: BEAT_W] = beat;
      end
    end
  end

  assign last = cap && (beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      line_q   <= '0;
    end else if (cap) begin
      line_q   <= line_nxt;
      beat_cnt <= last ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory read bus between instruction and data caches.
// A granted request is held on the bus until BEATS beats arrive, then the
// assembled line is presented to the owner for one cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_addr/i_rd       : instruction-cache block address / refill request
//   i_data/i_dv       : line to instruction cache / one-cycle valid
//   d_addr/d_rd       : data-cache block address / refill request
//   d_data/d_dv       : line to data cache / one-cycle valid
//   m_addr/m_rd       : memory block address / read strobe
//   m_data/m_dv       : memory beat / beat valid
//   busy              : arbiter not idle
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; otherwise
// the data cache always wins a tie.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [BLK_LEN-1:0] i_addr,
  input  logic               i_rd,
  output logic [LINE_W-1:0]  i_data,
  output logic               i_dv,
  input  logic [BLK_LEN-1:0] d_addr,
  input  logic               d_rd,
  output logic [LINE_W-1:0]  d_data,
  output logic               d_dv,
  output logic [BLK_LEN-1:0] m_addr,
  output logic               m_rd,
  input  logic [BEAT_W-1:0]  m_data,
  input  logic               m_dv,
  output logic               busy
);

  state_t             state, state_nxt;
  req_id_t            gnt_id;
  req_id_t            win_id;
  logic [BLK_LEN-1:0] addr_q;
  logic               mask_vld;
  logic               i_req, d_req;
  logic               grant;
  logic               cap;
  logic               last;
  logic [LINE_W-1:0]  line_nxt;
`ifdef MEM_ARB_RR_EN
  req_id_t            last_gnt;
`endif

  // The requester just served still has rd high for one cycle after its dv.
  assign i_req = i_rd && !(mask_vld && (gnt_id == REQ_I));
  assign d_req = d_rd && !(mask_vld && (gnt_id == REQ_D));

  always_comb begin
    win_id = REQ_I;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      win_id = (last_gnt == REQ_I) ? REQ_D : REQ_I;
`else
      win_id = REQ_D;
`endif
    end else if (d_req) begin
      win_id = REQ_D;
    end
  end

  assign grant = (state == ST_IDLE) && (i_req || d_req);
  assign cap   = (state == ST_BUS) && m_dv;

  mem_arb_linebuf u_linebuf (
    .clk      (clk),
    .rst      (rst),
    .cap      (cap),
    .beat     (m_data),
    .line_nxt (line_nxt),
    .last     (last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_BUS;
      ST_BUS:  if (last)  state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_id   <= REQ_I;
      addr_q   <= '0;
      mask_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      mask_vld <= (state == ST_RESP);
      if (grant) begin
        gnt_id <= win_id;
        addr_q <= (win_id == REQ_D) ? d_addr : i_addr;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Reset to instruction so the data cache wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= REQ_I;
    end else if (grant) begin
      last_gnt <= win_id;
    end
  end
`endif

  // Lines are latched on the final beat so they are stable during RESP and
  // held until the next delivery to the same cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_data <= '0;
      d_data <= '0;
    end else if (last) begin
      if (gnt_id == REQ_I) i_data <= line_nxt;
      else                 d_data <= line_nxt;
    end
  end

  assign m_rd   = (state == ST_BUS);
  assign m_addr = addr_q;
  assign busy   = (state != ST_IDLE);
  assign i_dv   = (state == ST_RESP) && (gnt_id == REQ_I);
  assign d_dv   = (state == ST_RESP) && (gnt_id == REQ_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [BLK_LEN-1:0] i_addr, d_addr, m_addr;
  logic               i_rd, d_rd, m_rd;
  logic [LINE_W-1:0]  i_data, d_data;
  logic               i_dv, d_dv, m_dv, busy;
  logic [BEAT_W-1:0]  m_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .i_addr (i_addr),
    .i_rd   (i_rd),
    .i_data (i_data),
    .i_dv   (i_dv),
    .d_addr (d_addr),
    .d_rd   (d_rd),
    .d_data (d_data),
    .d_dv   (d_dv),
    .m_addr (m_addr),
    .m_rd   (m_rd),
    .m_data (m_data),
    .m_dv   (m_dv),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how many beats arrived, the beats
  // themselves, and the last line delivered to each cache.
  bit                 mx_xfer, mx_resp;
  int                 mx_owner, mx_got, mx_mask, mx_last;
  logic [BLK_LEN-1:0] mx_addr;
  logic [BEAT_W-1:0]  mx_beats [BEATS];
  logic [LINE_W-1:0]  mx_iline, mx_dline;

  task automatic model_reset();
    mx_xfer  = 0;
    mx_resp  = 0;
    mx_owner = 0;
    mx_got   = 0;
    mx_mask  = -1;
    mx_last  = 0;
    mx_addr  = '0;
    mx_iline = '0;
    mx_dline = '0;
  endtask

  task automatic model_edge();
    logic [LINE_W-1:0] ln;
    bit ireq, dreq;
    int win;
    if (rst) begin
      model_reset();
    end else if (mx_resp) begin
      mx_resp = 0;
      mx_mask = mx_owner;
    end else if (mx_xfer) begin
      if (m_dv) begin
        mx_beats[mx_got] = m_data;
        mx_got++;
        if (mx_got == BEATS) begin
          for (int k = 0; k < BEATS; k++) ln[k*BEAT_W +: BEAT_W] = mx_beats[k];
          if (mx_owner == 0) mx_iline = ln;
          else               mx_dline = ln;
          mx_xfer = 0;
          mx_resp = 1;
          mx_got  = 0;
        end
      end
    end else begin
      ireq = i_rd && (mx_mask != 0);
      dreq = d_rd && (mx_mask != 1);
      mx_mask = -1;
      if (ireq || dreq) begin
        if (ireq && dreq) begin
`ifdef MEM_ARB_RR_EN
          win = (mx_last == 1) ? 0 : 1;
`else
          win = 1;
`endif
        end else begin
          win = dreq ? 1 : 0;
        end
        mx_last  = win;
        mx_owner = win;
        mx_addr  = (win == 1) ? d_addr : i_addr;
        mx_xfer  = 1;
        mx_got   = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_idv();
    return mx_resp && (mx_owner == 0);
  endfunction

  function automatic bit exp_ddv();
    return mx_resp && (mx_owner == 1);
  endfunction

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_rd",   m_rd,   mx_xfer);
    chk("busy",   busy,   mx_xfer || mx_resp);
    chk("i_dv",   i_dv,   exp_idv());
    chk("d_dv",   d_dv,   exp_ddv());
    chk("i_data", i_data, mx_iline);
    chk("d_data", d_data, mx_dline);
    if (mx_xfer) chk("m_addr", m_addr, mx_addr);
  endtask

  // n beats, each preceded by gap idle cycles, data base+k.
  task automatic beats(input int n, input int gap, input logic [BEAT_W-1:0] base);
    for (int k = 0; k < n; k++) begin
      m_dv = 1'b0;
      for (int g = 0; g < gap; g++) step();
      m_dv   = 1'b1;
      m_data = base + BEAT_W'(k);
      step();
      m_dv = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LINE_W-1:0] line;
    bit i_hold, d_hold;
    model_reset();
    rst = 1'b1; i_rd = 1'b0; d_rd = 1'b0; m_dv = 1'b0;
    i_addr = '0; d_addr = '0; m_data = '0;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_rd", m_rd, 1'b0);
    rst = 1'b0;
    step();

    // Lone data request, beats 3 cycles apart.
    d_addr = BLK_LEN'(32'h12); d_rd = 1'b1;
    step();
    chk("a_m_addr", m_addr, BLK_LEN'(32'h12));
    chk("a_m_rd", m_rd, 1'b1);
    beats(4, 2, 64'hA0);
    line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    chk("a_d_dv", d_dv, 1'b1);
    chk("a_i_dv", i_dv, 1'b0);
    chk("a_d_data", d_data, line);
    step();                     // first idle, d_rd still high
    step();                     // masked: no re-grant
    chk("a_mask_busy", busy, 1'b0);
    d_rd = 1'b0;
    step();
    d_rd = 1'b1;                // raised again two cycles later
    step();
    chk("a_regrant", m_rd, 1'b1);
    beats(4, 0, 64'hC0);
    d_rd = 1'b0;
    step(); step();

    // Tie after reset: data first, instruction right after the mask cycle.
    rst = 1'b1; step(); rst = 1'b0;
    i_addr = BLK_LEN'(32'h33); d_addr = BLK_LEN'(32'h44);
    i_rd = 1'b1; d_rd = 1'b1;
    step();
    chk("b_first", m_addr, BLK_LEN'(32'h44));
    beats(4, 0, 64'h10);
    chk("b_d_dv", d_dv, 1'b1);
    step();                     // mask cycle, d_rd still high
    step();
    chk("b_second", m_addr, BLK_LEN'(32'h33));
    chk("b_second_rd", m_rd, 1'b1);
    d_rd = 1'b0;
    beats(4, 1, 64'h20);
    chk("b_i_dv", i_dv, 1'b1);
    i_rd = 1'b0;
    step(); step();

    // Reset mid-transfer, then a clean instruction refill.
    d_addr = BLK_LEN'(32'h55); d_rd = 1'b1;
    step();
    beats(2, 1, 64'h70);
    rst = 1'b1;
    step();
    chk("c_m_rd", m_rd, 1'b0);
    chk("c_busy", busy, 1'b0);
    chk("c_d_dv", d_dv, 1'b0);
    rst = 1'b0; d_rd = 1'b0;
    i_addr = BLK_LEN'(32'h66); i_rd = 1'b1;
    step();
    chk("c_m_addr", m_addr, BLK_LEN'(32'h66));
    beats(4, 1, 64'h90);
    line = {64'h93, 64'h92, 64'h91, 64'h90};
    chk("c_i_data", i_data, line);
    chk("c_i_dv", i_dv, 1'b1);
    i_rd = 1'b0;
    step(); step();

    // Stray beats while idle, address change during the bus phase.
    m_dv = 1'b1; m_data = 64'hDEAD;
    step(); step(); step();
    chk("d_idle_busy", busy, 1'b0);
    m_dv = 1'b0;
    d_addr = BLK_LEN'(32'h21); d_rd = 1'b1;
    step();
    d_addr = BLK_LEN'(32'h2F);
    beats(1, 1, 64'hB0);
    chk("d_addr_hold", m_addr, BLK_LEN'(32'h21));
    beats(3, 1, 64'hB1);
    line = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
    chk("d_d_data", d_data, line);
    chk("d_i_dv", i_dv, 1'b0);
    d_rd = 1'b0;
    step(); step();

    // Randomized traffic: requesters hold rd until one cycle after their dv.
    i_hold = 0; d_hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (exp_idv())                 i_hold = 1;
      else if (i_hold)               begin i_rd = 1'b0; i_hold = 0; end
      else if (!i_rd && $urandom_range(0, 3) == 0) begin
        i_rd = 1'b1; i_addr = BLK_LEN'($urandom);
      end
      if (exp_ddv())                 d_hold = 1;
      else if (d_hold)               begin d_rd = 1'b0; d_hold = 0; end
      else if (!d_rd && $urandom_range(0, 3) == 0) begin
        d_rd = 1'b1; d_addr = BLK_LEN'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        i_addr = BLK_LEN'($urandom);
        d_addr = BLK_LEN'($urandom);
      end
      m_dv   = ($urandom_range(0, 1) == 1);
      m_data = {$urandom, $urandom};
      rst    = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
